// File: rtl/mux4_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux4_rr_scheduler_pkg
// Brief   : Shared encodings and helpers for the 4-way round-robin mux scheduler
// Revision: 1.0 - initial release
// ============================================================================
package mux4_rr_scheduler_pkg;

  localparam int IDX_W = 2;
  localparam int N_REQ = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Pointer reset value: requester 0 wins the first search after reset
  localparam logic [IDX_W-1:0] PTR_RST = 2'b11;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_scheduler_mux4.sv
`default_nettype none
// ============================================================================
// Module  : mux4
// Brief   : Structural single-bit 4:1 mux datapath
// Revision: 1.0 - initial release
// ============================================================================
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  logic w_lo;
  logic w_hi;

  assign w_lo = s[0] ? d[1] : d[0];
  assign w_hi = s[0] ? d[3] : d[2];
  assign y    = s[1] ? w_hi : w_lo;

endmodule
`default_nettype wire

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick4
// Brief   : Combinational first-set search over 4 requests starting at base
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux4_rr_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest hit is written last
  always_comb begin
    found  = 1'b0;
    idx    = base;
    w_cand = base;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = base + IDX_W'(k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : mux4_rr_scheduler
// Brief   : Round-robin select sequencer with bounded hold for a shared 4:1 mux
// Revision: 1.0 - initial release
// ============================================================================
module mux4_rr_scheduler
  import mux4_rr_scheduler_pkg::*;
#(
  parameter int HOLD = 2,
  parameter int CW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] D,
  output logic [IDX_W-1:0] S,
  output logic [N_REQ-1:0] gnt,
  output logic             y,
  output logic             y_valid,
  output logic             busy
);

  localparam logic [CW-1:0] c_reload = CW'(HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_last;
  logic [CW-1:0]    r_cnt;

  logic [IDX_W-1:0] w_base;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_mux_y;
  logic             w_cur_req;
  logic             w_release;

  assign w_base    = (r_state == ST_GRANT) ? (S + 2'd1) : (r_last + 2'd1);
  assign w_cur_req = req[S];
  assign w_release = (r_cnt == '0) || !w_cur_req;
  assign busy      = (r_state == ST_GRANT);

  rr_pick4 u_pick (
    .req   (req),
    .base  (w_base),
    .found (w_found),
    .idx   (w_idx)
  );

  mux4 u_mux (
    .d (D),
    .s (S),
    .y (w_mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= PTR_RST;
      r_cnt   <= '0;
      S       <= '0;
      gnt     <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          y_valid <= 1'b0;
          gnt     <= '0;
          if (w_found) begin
            r_state <= ST_GRANT;
            S       <= w_idx;
            gnt     <= onehot(w_idx);
            r_cnt   <= c_reload;
            r_last  <= w_idx;
          end
        end
        ST_GRANT: begin
          y       <= w_mux_y;
          y_valid <= w_cur_req;
          if (!w_release) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_found) begin
            // Back-to-back handover: no idle cycle between grants
            S      <= w_idx;
            gnt    <= onehot(w_idx);
            r_cnt  <= c_reload;
            r_last <= w_idx;
          end else begin
            r_state <= ST_IDLE;
            gnt     <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          gnt     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux4_rr_scheduler
// Brief   : Directed self-checking bench for mux4_rr_scheduler (HOLD=1,2,4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux4_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req2, d2, req4, d4, req1, d1;
  logic [1:0] s2, s4, s1;
  logic [3:0] g2, g4, g1;
  logic       y2, yv2, b2, y4, yv4, b4, y1, yv1, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_scheduler #(.HOLD(2), .CW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .D(d2),
    .S(s2), .gnt(g2), .y(y2), .y_valid(yv2), .busy(b2));

  mux4_rr_scheduler #(.HOLD(4), .CW(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .D(d4),
    .S(s4), .gnt(g4), .y(y4), .y_valid(yv4), .busy(b4));

  mux4_rr_scheduler #(.HOLD(1), .CW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .D(d1),
    .S(s1), .gnt(g1), .y(y1), .y_valid(yv1), .busy(b1));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; release lands before the next edge
  task automatic do_reset;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [8];
    logic [7:0] exp_y;
    logic [3:0] rot_g [5];
    logic       rot_y [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_y = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    req2 = 4'b1111; d2 = 4'b0110;
    req4 = 4'b0000; d4 = 4'b0000;
    req1 = 4'b0000; d1 = 4'b0000;

    // 1. reset hold with all requesting
    for (int i = 0; i < 2; i++) begin
      step;
      check("rst_s", 8'(s2), 8'h0);
      check("rst_gnt", 8'(g2), 8'h0);
      check("rst_y", 8'(y2), 8'h0);
      check("rst_yv", 8'(yv2), 8'h0);
      check("rst_busy", 8'(b2), 8'h0);
    end
    rst_n = 1'b1;
    step;
    check("first_gnt", 8'(g2), 8'h01);
    check("first_s", 8'(s2), 8'h0);
    check("first_busy", 8'(b2), 8'h1);
    check("first_yv", 8'(yv2), 8'h0);

    // 2. fair rotation with HOLD=2, y lags by one cycle
    for (int i = 0; i < 8; i++) begin
      step;
      check($sformatf("rot2_gnt%0d", i), 8'(g2), 8'(exp_g[i]));
      check($sformatf("rot2_y%0d", i), 8'(y2), 8'((i >= 2 && i <= 5) ? 1 : 0));
      check($sformatf("rot2_yv%0d", i), 8'(yv2), 8'h1);
    end

    // 3. single requester keeps the grant, D sampled live
    req2 = 4'b0100;
    do_reset;
    step;
    check("solo_gnt0", 8'(g2), 8'h04);
    check("solo_s0", 8'(s2), 8'h2);
    for (int i = 0; i < 4; i++) begin
      d2 = (i % 2 == 1) ? 4'b0000 : 4'b0100;
      exp_y = 8'(d2[2]);
      step;
      check($sformatf("solo_gnt%0d", i + 1), 8'(g2), 8'h04);
      check($sformatf("solo_y%0d", i + 1), 8'(y2), exp_y);
      check($sformatf("solo_yv%0d", i + 1), 8'(yv2), 8'h1);
    end
    req2 = 4'b0000;
    step;
    check("drop_gnt", 8'(g2), 8'h0);
    check("drop_busy", 8'(b2), 8'h0);
    check("drop_yv", 8'(yv2), 8'h0);
    step;
    check("idle_yv", 8'(yv2), 8'h0);
    check("idle_s_hold", 8'(s2), 8'h2);

    // 4. early release with HOLD=4
    req4 = 4'b0011; d4 = 4'b0011;
    do_reset;
    step;
    check("early_gnt0", 8'(g4), 8'h01);
    step;
    check("early_gnt1", 8'(g4), 8'h01);
    check("early_yv1", 8'(yv4), 8'h1);
    req4 = 4'b0010;
    step;
    check("early_gnt2", 8'(g4), 8'h02);
    check("early_s2", 8'(s4), 8'h1);
    check("early_yv2", 8'(yv4), 8'h0);
    step;
    check("early_gnt3", 8'(g4), 8'h02);
    check("early_yv3", 8'(yv4), 8'h1);
    check("early_y3", 8'(y4), 8'h1);
    req4 = 4'b0000;

    // 5. wrap from 3 to 0 and back
    req2 = 4'b1000;
    do_reset;
    step;
    check("wrap_gnt0", 8'(g2), 8'h08);
    req2 = 4'b1001;
    step;
    check("wrap_gnt1", 8'(g2), 8'h08);
    step;
    check("wrap_gnt2", 8'(g2), 8'h01);
    step;
    check("wrap_gnt3", 8'(g2), 8'h01);
    step;
    check("wrap_gnt4", 8'(g2), 8'h08);
    check("wrap_s4", 8'(s2), 8'h3);

    // 6. async reset mid-grant, pointer restarts at 3
    req2 = 4'b0010; d2 = 4'b0010;
    do_reset;
    step;
    check("areset_pre_gnt", 8'(g2), 8'h02);
    step;
    check("areset_pre_y", 8'(y2), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_gnt", 8'(g2), 8'h0);
    check("areset_s", 8'(s2), 8'h0);
    check("areset_y", 8'(y2), 8'h0);
    check("areset_yv", 8'(yv2), 8'h0);
    check("areset_busy", 8'(b2), 8'h0);
    req2 = 4'b1010;
    rst_n = 1'b1;
    step;
    check("areset_regnt", 8'(g2), 8'h02);
    check("areset_regnt_s", 8'(s2), 8'h1);
    req2 = 4'b0000;

    // HOLD=1: one-cycle grants, pure rotation
    req1 = 4'b1111; d1 = 4'b1010;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      step;
      check($sformatf("h1_gnt%0d", i), 8'(g1), 8'(rot_g[i]));
      check($sformatf("h1_y%0d", i), 8'(y1), 8'(rot_y[i]));
      check($sformatf("h1_yv%0d", i), 8'(yv1), 8'((i > 0) ? 1 : 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
